// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed 7-segment scanner.
package seg7_scan_mux_pkg;

  // One-hot digit-select values produced by the upstream ring counter
  localparam logic [3:0] PH_D0 = 4'b0001;
  localparam logic [3:0] PH_D1 = 4'b0010;
  localparam logic [3:0] PH_D2 = 4'b0100;
  localparam logic [3:0] PH_D3 = 4'b1000;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // True when exactly one bit of the phase is set
  function automatic logic isOneHot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Phase that legally follows v in the ring 1->2->4->8->1
  function automatic logic [3:0] nextPhase(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-high 7-segment pattern; 10..15 show a dash.
module seg7_decode
  import seg7_scan_mux_pkg::*;
(
  input  logic [3:0] iBcd,
  output logic [6:0] oSegs
);

  // Pure lookup, no state
  always_comb begin
    oSegs = SEG_DASH;
    case (iBcd)
      4'd0:    oSegs = SEG_0;
      4'd1:    oSegs = SEG_1;
      4'd2:    oSegs = SEG_2;
      4'd3:    oSegs = SEG_3;
      4'd4:    oSegs = SEG_4;
      4'd5:    oSegs = SEG_5;
      4'd6:    oSegs = SEG_6;
      4'd7:    oSegs = SEG_7;
      4'd8:    oSegs = SEG_8;
      4'd9:    oSegs = SEG_9;
      default: oSegs = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// 4-digit multiplexed 7-segment driver fed by a one-hot ring-counter phase.
// Display data is double-buffered and swapped only at frame boundaries.
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter logic ANODE_ACTIVE_LOW = 1'b1,
  parameter logic SEG_ACTIVE_LOW   = 1'b1,
  parameter logic LZ_BLANK         = 1'b1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [3:0]  iPhase,
  input  logic [15:0] iData,
  input  logic [3:0]  iDp,
  input  logic        iLoad,
  output logic [3:0]  oAnode,
  output logic [6:0]  oSeg,
  output logic        oDp,
  output logic        oLoadAck,
  output logic        oFrame,
  output logic        oSeqErr
);

  logic [3:0]  rPhase_Q;
  logic        firstQ;
  logic [15:0] activeData;
  logic [3:0]  activeDp;
  logic [15:0] pendData;
  logic [3:0]  pendDp;
  logic        pendValid;

  logic        frameHit;
  logic        orderBad;
  logic        illegalNow;
  logic        blank1, blank2, blank3;
  logic        selOk;
  logic        selBlank;
  logic        selDp;
  logic [3:0]  selNib;
  logic [6:0]  decSegs;
  logic [6:0]  segLit;
  logic [3:0]  anodeEn;
  logic        dpLit;

  // Map an active-high enable/lit vector to the pin level
  function automatic logic [3:0] anodeLevel(input logic [3:0] en);
    return ANODE_ACTIVE_LOW ? ~en : en;
  endfunction

  function automatic logic [6:0] segLevel(input logic [6:0] lit);
    return SEG_ACTIVE_LOW ? ~lit : lit;
  endfunction

  function automatic logic dpLevel(input logic lit);
    return SEG_ACTIVE_LOW ? ~lit : lit;
  endfunction

  // Stage 0 -> 1: phase events seen against the incoming phase
  always_comb begin
    frameHit   = (iPhase == PH_D0) && (rPhase_Q != PH_D0);
    orderBad   = isOneHot4(iPhase) && isOneHot4(rPhase_Q) &&
                 (iPhase != rPhase_Q) && (iPhase != nextPhase(rPhase_Q));
    // An all-zero phase is tolerated only while the ring counter comes out of reset
    illegalNow = !isOneHot4(rPhase_Q) && !((rPhase_Q == 4'd0) && firstQ);
  end

  // Leading-zero blanking: a digit blanks when it and all higher digits are zero
  always_comb begin
    blank3 = LZ_BLANK && (activeData[15:12] == 4'd0);
    blank2 = blank3 && (activeData[11:8] == 4'd0);
    blank1 = blank2 && (activeData[7:4] == 4'd0);
  end

  // Stage 1 -> 2: pick the digit addressed by the registered phase
  always_comb begin
    selOk    = 1'b1;
    selNib   = activeData[3:0];
    selDp    = activeDp[0];
    selBlank = 1'b0;
    case (rPhase_Q)
      PH_D0: begin selNib = activeData[3:0];   selDp = activeDp[0]; selBlank = 1'b0;   end
      PH_D1: begin selNib = activeData[7:4];   selDp = activeDp[1]; selBlank = blank1; end
      PH_D2: begin selNib = activeData[11:8];  selDp = activeDp[2]; selBlank = blank2; end
      PH_D3: begin selNib = activeData[15:12]; selDp = activeDp[3]; selBlank = blank3; end
      default: selOk = 1'b0;
    endcase
  end

  seg7_decode uDecode (
    .iBcd  (selNib),
    .oSegs (decSegs)
  );

  // Active-high view of what the selected digit should show
  always_comb begin
    anodeEn = selOk ? rPhase_Q : 4'd0;
    segLit  = (selOk && !selBlank) ? decSegs : SEG_BLANK;
    dpLit   = selOk && selDp;
  end

  // Phase pipeline, frame detection, buffer swap and sticky sequence error
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rPhase_Q   <= 4'd0;
      firstQ     <= 1'b1;
      oFrame     <= 1'b0;
      oLoadAck   <= 1'b0;
      oSeqErr    <= 1'b0;
      pendValid  <= 1'b0;
      activeData <= 16'd0;
      activeDp   <= 4'd0;
    end else begin
      rPhase_Q <= iPhase;
      firstQ   <= 1'b0;
      oFrame   <= frameHit;
      oLoadAck <= frameHit && pendValid;
      if (frameHit && pendValid) begin
        activeData <= pendData;
        activeDp   <= pendDp;
        pendValid  <= 1'b0;
      end
      // A load in the swap cycle refills pending after the old value committed
      if (iLoad) begin
        pendValid <= 1'b1;
      end
      if (illegalNow || orderBad) begin
        oSeqErr <= 1'b1;
      end
    end
  end

  // Pending data payload; its validity flag lives with the control state
  always_ff @(posedge iClk) begin
    if (iLoad) begin
      pendData <= iData;
      pendDp   <= iDp;
    end
  end

  // Stage 2: registered pin drivers with polarity applied last
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oAnode <= {4{ANODE_ACTIVE_LOW}};
      oSeg   <= {7{SEG_ACTIVE_LOW}};
      oDp    <= SEG_ACTIVE_LOW;
    end else begin
      oAnode <= anodeLevel(anodeEn);
      oSeg   <= segLevel(segLit);
      oDp    <= dpLevel(dpLit);
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (default parameters: active-low pins, blanking on).
module tb_seg7_scan_mux;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic [3:0]  iPhase = 4'd0;
  logic [15:0] iData = 16'd0;
  logic [3:0]  iDp = 4'd0;
  logic        iLoad = 1'b0;
  logic [3:0]  oAnode;
  logic [6:0]  oSeg;
  logic        oDp;
  logic        oLoadAck;
  logic        oFrame;
  logic        oSeqErr;

  seg7_scan_mux dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iPhase   (iPhase),
    .iData    (iData),
    .iDp      (iDp),
    .iLoad    (iLoad),
    .oAnode   (oAnode),
    .oSeg     (oSeg),
    .oDp      (oDp),
    .oLoadAck (oLoadAck),
    .oFrame   (oFrame),
    .oSeqErr  (oSeqErr)
  );

  always #5 iClk = ~iClk;

  int nCmp = 0;
  int nFail = 0;
  int ackCount = 0;
  int curIdx = 0;

  logic [6:0] SEGTAB [16];

  // Reference model state
  logic [3:0]  mPh;
  logic        mFirst;
  logic [15:0] mActive;
  logic [3:0]  mActiveDp;
  logic [15:0] mPendD;
  logic [3:0]  mPendDp;
  logic        mPendV;
  logic        mErr;
  logic [14:0] expVec;

  localparam logic [14:0] RST_PINS = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    int          digit;
    logic [6:0]  seg;
    logic        dpLit;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int idxOf(input logic [3:0] ph);
    int k = 0;
    for (int i = 0; i < 4; i++) if (ph[i]) k = i;
    return k;
  endfunction

  // Expected pin values {anode, seg, dp} for a given phase and display buffer
  function automatic logic [11:0] expDisp(input logic [3:0] ph, input logic [15:0] d, input logic [3:0] dp);
    logic [3:0] an;
    logic [6:0] sg;
    logic       p;
    int         k;
    an = 4'd0; sg = 7'd0; p = 1'b0;
    if ($countones(ph) == 1) begin
      k  = idxOf(ph);
      an = 4'b0001 << k;
      p  = dp[k];
      if (k > 0 && (d >> (4 * k)) == 16'd0) sg = 7'd0;
      else sg = SEGTAB[d[4*k +: 4]];
    end
    return {~an, ~sg, ~p};
  endfunction

  task automatic modelReset();
    mPh = 4'd0; mFirst = 1'b1; mActive = 16'd0; mActiveDp = 4'd0;
    mPendV = 1'b0; mErr = 1'b0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs
  task automatic modelEdge();
    logic [11:0] disp;
    logic        eFrame, eAck;
    disp   = expDisp(mPh, mActive, mActiveDp);
    eFrame = (iPhase == 4'b0001) && (mPh != 4'b0001);
    eAck   = eFrame && mPendV;
    if (eAck) begin mActive = mPendD; mActiveDp = mPendDp; mPendV = 1'b0; end
    if (iLoad) begin mPendD = iData; mPendDp = iDp; mPendV = 1'b1; end
    if ($countones(mPh) != 1 && !(mPh == 4'd0 && mFirst)) mErr = 1'b1;
    if ($countones(mPh) == 1 && $countones(iPhase) == 1 && iPhase != mPh &&
        idxOf(iPhase) != (idxOf(mPh) + 1) % 4) mErr = 1'b1;
    mFirst = 1'b0;
    mPh    = iPhase;
    expVec = {disp, eAck, eFrame, mErr};
  endtask

  task automatic tick(input logic [3:0] ph, input logic ld, input logic [15:0] d, input logic [3:0] dp);
    iPhase = ph; iLoad = ld; iData = d; iDp = dp;
    modelEdge();
    @(posedge iClk);
    #1;
    iLoad = 1'b0;
    if (oLoadAck) ackCount++;
    check("cycle", {17'd0, oAnode, oSeg, oDp, oLoadAck, oFrame, oSeqErr}, {17'd0, expVec});
  endtask

  task automatic runCycle(input logic ld, input logic [15:0] d, input logic [3:0] dp);
    logic [3:0] ph;
    ph = 4'b0001 << curIdx;
    tick(ph, ld, d, dp);
    curIdx = (curIdx + 1) % 4;
  endtask

  task automatic doReset();
    iLoad = 1'b0;
    iRst  = 1'b1;
    #1;
    modelReset();
    check("reset_pins", {17'd0, oAnode, oSeg, oDp, oLoadAck, oFrame, oSeqErr}, {17'd0, RST_PINS});
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    curIdx = 0;
    ackCount = 0;
  endtask

  initial begin
    vec_t       v;
    logic [3:0] anExp;
    logic [6:0] segExp;
    logic [3:0] lastPh;
    logic [3:0] ph;
    logic [15:0] rd;
    int         r;

    SEGTAB = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    vt[0]  = '{16'h1234, 4'h0, 0, 7'h66, 1'b0};
    vt[1]  = '{16'h1234, 4'h0, 1, 7'h4F, 1'b0};
    vt[2]  = '{16'h1234, 4'h0, 2, 7'h5B, 1'b0};
    vt[3]  = '{16'h1234, 4'h0, 3, 7'h06, 1'b0};
    vt[4]  = '{16'h0050, 4'h0, 3, 7'h00, 1'b0};
    vt[5]  = '{16'h0050, 4'h0, 2, 7'h00, 1'b0};
    vt[6]  = '{16'h0050, 4'h0, 1, 7'h6D, 1'b0};
    vt[7]  = '{16'h0050, 4'h0, 0, 7'h3F, 1'b0};
    vt[8]  = '{16'h0000, 4'h0, 1, 7'h00, 1'b0};
    vt[9]  = '{16'hAAAA, 4'hF, 2, 7'h40, 1'b1};
    vt[10] = '{16'h7089, 4'h4, 2, 7'h3F, 1'b1};
    vt[11] = '{16'h0009, 4'h8, 3, 7'h00, 1'b1};

    #2;
    doReset();

    // Table: load a value, let it commit, then look at one digit
    for (int t = 0; t < 12; t++) begin
      v = vt[t];
      doReset();
      runCycle(1'b1, v.data, v.dp);
      for (int c = 0; c < 4; c++) runCycle(1'b0, 16'd0, 4'd0);
      for (int c = 0; c < 4 && curIdx != v.digit; c++) runCycle(1'b0, 16'd0, 4'd0);
      runCycle(1'b0, 16'd0, 4'd0);
      runCycle(1'b0, 16'd0, 4'd0);
      anExp  = ~(4'b0001 << v.digit);
      segExp = ~v.seg;
      check("tab_anode", {28'd0, oAnode}, {28'd0, anExp});
      check("tab_seg", {25'd0, oSeg}, {25'd0, segExp});
      check("tab_dp", {31'd0, oDp}, {31'd0, ~v.dpLit});
      check("tab_ack_once", ackCount, 1);
      check("tab_no_err", {31'd0, oSeqErr}, 32'd0);
    end

    // Two loads in one frame: last wins, single ack
    doReset();
    runCycle(1'b0, 16'd0, 4'd0);
    runCycle(1'b1, 16'h1111, 4'd0);
    runCycle(1'b1, 16'h2222, 4'd0);
    runCycle(1'b0, 16'd0, 4'd0);
    runCycle(1'b0, 16'd0, 4'd0);
    runCycle(1'b0, 16'd0, 4'd0);
    check("two_loads_seg", {25'd0, oSeg}, {25'd0, ~7'h5B});
    for (int c = 0; c < 8; c++) runCycle(1'b0, 16'd0, 4'd0);
    check("two_loads_ack", ackCount, 1);

    // Load coincident with the boundary while AAAA is pending
    doReset();
    runCycle(1'b0, 16'd0, 4'd0);
    runCycle(1'b1, 16'hAAAA, 4'd0);
    runCycle(1'b0, 16'd0, 4'd0);
    runCycle(1'b0, 16'd0, 4'd0);
    runCycle(1'b1, 16'h5555, 4'd0);
    check("bnd_ack1", {31'd0, oLoadAck}, 32'd1);
    runCycle(1'b0, 16'd0, 4'd0);
    check("bnd_dash", {25'd0, oSeg}, {25'd0, ~7'h40});
    runCycle(1'b0, 16'd0, 4'd0);
    runCycle(1'b0, 16'd0, 4'd0);
    runCycle(1'b0, 16'd0, 4'd0);
    check("bnd_ack2", {31'd0, oLoadAck}, 32'd1);
    runCycle(1'b0, 16'd0, 4'd0);
    check("bnd_new5", {25'd0, oSeg}, {25'd0, ~7'h6D});

    // Skipped phase 1->4 sets a sticky error
    doReset();
    tick(4'b0001, 1'b0, 16'd0, 4'd0);
    tick(4'b0100, 1'b0, 16'd0, 4'd0);
    tick(4'b1000, 1'b0, 16'd0, 4'd0);
    check("skip_err", {31'd0, oSeqErr}, 32'd1);
    curIdx = 0;
    for (int c = 0; c < 8; c++) runCycle(1'b0, 16'd0, 4'd0);
    check("skip_sticky", {31'd0, oSeqErr}, 32'd1);

    // Two-hot phase blanks everything and flags the error; reset clears it
    doReset();
    check("err_cleared", {31'd0, oSeqErr}, 32'd0);
    tick(4'b0001, 1'b0, 16'd0, 4'd0);
    tick(4'b0010, 1'b0, 16'd0, 4'd0);
    tick(4'b0011, 1'b0, 16'd0, 4'd0);
    tick(4'b0100, 1'b0, 16'd0, 4'd0);
    check("twohot_anode", {28'd0, oAnode}, 32'hF);
    check("twohot_seg", {25'd0, oSeg}, 32'h7F);
    tick(4'b1000, 1'b0, 16'd0, 4'd0);
    check("twohot_err", {31'd0, oSeqErr}, 32'd1);

    // Reset mid-frame with pending valid discards it
    doReset();
    runCycle(1'b0, 16'd0, 4'd0);
    runCycle(1'b1, 16'h9999, 4'hF);
    runCycle(1'b0, 16'd0, 4'd0);
    doReset();
    for (int c = 0; c < 10; c++) runCycle(1'b0, 16'd0, 4'd0);
    check("rst_no_ack", ackCount, 0);

    // Randomized traffic against the model
    doReset();
    lastPh = 4'b1000;
    for (int i = 0; i < 600; i++) begin
      if (i == 250) begin
        doReset();
        lastPh = 4'b1000;
      end
      r = int'($urandom_range(0, 39));
      if ($countones(lastPh) != 1) ph = 4'b0001;
      else if (r == 0 && i > 450) ph = 4'($urandom_range(0, 15));
      else if (r == 1) ph = lastPh;
      else if (r == 2 && i > 450) ph = {lastPh[1:0], lastPh[3:2]};
      else ph = {lastPh[2:0], lastPh[3]};
      for (int n = 0; n < 4; n++)
        rd[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      tick(ph, ($urandom_range(0, 5) == 0), rd, 4'($urandom_range(0, 15)));
      lastPh = ph;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
